apb_reg_bank: RTL and testbench
===============================

# apb_reg_bank

Parametrised APB3/APB4 slave register bank. It is the next generation of the fixed four-register APB selector. It provides NUM_REGS word-wide registers with a proper setup/access handshake, programmable wait states, PREADY/PSLVERR, and hardware-owned read-only status registers. It sits between the APB interconnect and the encoder/decoder datapath, which consumes the flattened register outputs and per-register write pulses.

## Interface
- AMBA_ADDR_WIDTH, 20, APB address width
- AMBA_WORD, 32, data width; multiple of 8
- NUM_REGS, 8, register count, 2..64; IDX_W = clog2(NUM_REGS)
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 makes register i read-only (hardware status)
- WAIT_STATES, 0, extra access cycles before PREADY, 0..15
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- PADDR  in  AMBA_ADDR_WIDTH  byte address; bits [1:0] ignored
- PWDATA  in  AMBA_WORD  write data
- PSTRB  in  AMBA_WORD/8  byte strobes; port present only with APB_REG_PSTRB_EN
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PRDATA  out  AMBA_WORD  read data, registered
- PREADY  out  1  transfer completion, registered
- PSLVERR  out  1  error response, valid only while PREADY = 1
- status_in  in  NUM_REGS*AMBA_WORD  read-only register values; slice i = bits [i*AMBA_WORD +: AMBA_WORD]
- regs_out  out  NUM_REGS*AMBA_WORD  RW register contents; RO slices driven 0
- wr_pulse  out  NUM_REGS  one-cycle pulse after a committed write to register i

## Operation
- Decode: word index = PADDR[AMBA_ADDR_WIDTH-1:2]. The access is out-of-range if the index is ≥ NUM_REGS.
- FSM states:
  - IDLE → if PSEL & !PENABLE (setup): go to WAIT if WAIT_STATES > 0, else RESP. Load wait counter with WAIT_STATES-1.
  - WAIT → decrement counter; at 0 go to RESP.
  - RESP → PREADY = 1 for exactly one cycle, then IDLE.
- PSEL low in WAIT or RESP aborts the transfer: return to IDLE with no write, no pulse and PREADY low. PSEL & PENABLE seen in IDLE is a protocol error: ignored, state stays IDLE.
- Error cases: out-of-range read or write, or a write to an RO_MASK register. PSLVERR = 1 with PREADY, the write is suppressed, and PRDATA = 0 for error reads.
- Write commit: at the rising edge ending RESP, provided PSEL & PENABLE & PWRITE and no error. The regs_out slice updates at that edge, and wr_pulse[i] = 1 during the following cycle only.
- Read:
  - PRDATA is loaded at the edge entering RESP.
  - Source is the stored value for RW registers, or status_in sampled at that edge for RO registers.
  - PRDATA holds until the next read response.
  - Write transfers leave PRDATA unchanged.
- Write data and address are sampled at the commit edge; the master holds them stable per APB.

## Timing
- Reset values: PRDATA = 0, PREADY = 0, PSLVERR = 0, all regs_out = 0, wr_pulse = 0, FSM = IDLE, counter = 0.
- Latency, WAIT_STATES = W: setup in cycle T0, PREADY high in cycle T0+1+W. A zero-wait configuration gives a standard two-cycle APB transfer.
- Back-to-back transfers: a new setup is accepted in the cycle after RESP, so the minimum period is 2+W cycles.
- Reset mid-transfer: immediate return to IDLE. No write commits in the reset cycle and PREADY is low the next cycle.
- Register updated by write N is readable by transfer N+1 with no hazard.

## Configuration
- APB_REG_PSTRB_EN defined (APB4 mode):
  - PSTRB port exists; byte k of the target register updates only if PSTRB[k] = 1.
  - PSTRB = 0 on a valid write commits nothing and produces no wr_pulse, but still completes with PSLVERR = 0.
  - Reads ignore PSTRB.
- Undefined (APB3 mode): no PSTRB port; every committed write updates the full word.

## Test plan
- Reset then read all NUM_REGS=8 RW registers, W=0 → PREADY in 2nd cycle of each transfer, PRDATA = 0, PSLVERR = 0.
- Write 0xDEADBEEF to addr 0x08, then read 0x08 → regs_out slice 2 = 0xDEADBEEF, wr_pulse = 8'b0000_0100 for one cycle, read returns 0xDEADBEEF.
- RO_MASK = 8'h80, status_in slice 7 = 0x12345678: write 0x1C → PSLVERR = 1, no pulse; read 0x1C → 0x12345678 with PSLVERR = 0. Read 0x20 (out-of-range) → PSLVERR = 1, PRDATA = 0.
- WAIT_STATES = 3: write transfer → PREADY high exactly in cycle T0+4. Dropping PSEL in cycle T0+2 → no write, PREADY never asserted.
- Assert rst during a WAIT state → PREADY stays low, target register keeps its reset value 0, and the next transfer completes normally.
- APB_REG_PSTRB_EN: register = 0xFFFFFFFF, write 0x00000000 with PSTRB = 4'b0101 → 0xFF00FF00. PSTRB = 0 → unchanged, no wr_pulse.

Source files
------------

// File: rtl/apb_reg_bank.sv
// APB3/APB4 slave register bank with wait states, error response and read-only status registers.
// Define APB_REG_PSTRB_EN to add the PSTRB port and per-byte write strobes (APB4 mode).
//   state  | meaning
//   S_IDLE | waiting for a setup phase
//   S_WAIT | counting programmed wait states
//   S_RESP | PREADY high, write commits at the end of this cycle
module apb_reg_bank #(
    parameter int                AMBA_ADDR_WIDTH = 20,
    parameter int                AMBA_WORD       = 32,
    parameter int                NUM_REGS        = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK       = '0,
    parameter int                WAIT_STATES     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
    input  logic [AMBA_WORD-1:0]          PWDATA,
`ifdef APB_REG_PSTRB_EN
    input  logic [AMBA_WORD/8-1:0]        PSTRB,
`endif
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    output logic [AMBA_WORD-1:0]          PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic [NUM_REGS*AMBA_WORD-1:0] status_in,
    output logic [NUM_REGS*AMBA_WORD-1:0] regs_out,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int NB    = AMBA_WORD / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]                   state;
    logic [3:0]                   cnt;
    logic [AMBA_WORD-1:0]         regs_q [NUM_REGS];
    logic [AMBA_ADDR_WIDTH-3:0]   word_idx;
    logic [IDX_W-1:0]             idx;
    logic                         in_range;
    logic                         is_ro;
    logic                         err;
    logic                         enter_resp;
    logic                         commit;
    logic [NB-1:0]                strb;
    logic [AMBA_WORD-1:0]         rd_val;
    logic                         unused_addr_lsb;

    assign unused_addr_lsb = ^PADDR[1:0];

`ifdef APB_REG_PSTRB_EN
    assign strb = PSTRB;
`else
    assign strb = '1;
`endif

    assign word_idx = PADDR[AMBA_ADDR_WIDTH-1:2];
    assign idx      = word_idx[IDX_W-1:0];
    assign in_range = word_idx < (AMBA_ADDR_WIDTH-2)'(NUM_REGS);
    assign is_ro    = in_range && RO_MASK[idx];
    assign err      = !in_range || (PWRITE && is_ro);

    always_comb begin
        rd_val = '0;
        if (in_range) begin
            if (is_ro)
                rd_val = status_in[idx*AMBA_WORD +: AMBA_WORD];
            else
                rd_val = regs_q[idx];
        end
    end

    always_comb begin
        enter_resp = 1'b0;
        if (state == S_IDLE && PSEL && !PENABLE && WAIT_STATES == 0)
            enter_resp = 1'b1;
        else if (state == S_WAIT && PSEL && cnt == 4'd0)
            enter_resp = 1'b1;
    end

    // An all-zero strobe completes normally but must not touch the register or pulse.
    assign commit = (state == S_RESP) && PSEL && PENABLE && PWRITE && !err && (|strb);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            if (enter_resp) begin
                state   <= S_RESP;
                PREADY  <= 1'b1;
                PSLVERR <= err;
                if (!PWRITE)
                    PRDATA <= rd_val;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (PSEL && !PENABLE) begin
                            state <= S_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    S_WAIT: begin
                        if (!PSEL) begin
                            state <= S_IDLE;
                            cnt   <= 4'd0;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_RESP: begin
                        state   <= S_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                    end
                    default: begin
                        state   <= S_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                wr_pulse[idx] <= 1'b1;
                for (int k = 0; k < NB; k++)
                    if (strb[k])
                        regs_q[idx][8*k +: 8] <= PWDATA[8*k +: 8];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
            assign regs_out[g*AMBA_WORD +: AMBA_WORD] = RO_MASK[g] ? '0 : regs_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: a zero-wait instance with a read-only register 7 and a
// three-wait-state instance; table-driven transfers plus hand-written abort/reset/strobe sequences.
module tb_apb_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [19:0]  paddr;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic         penable, pwrite, psel0, psel3;
    logic [255:0] status0, status3;

    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;
    logic [255:0] regs0, regs3;
    logic [7:0]   pulse0, pulse3;

    int checks = 0;
    int errors = 0;

    apb_reg_bank #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .NUM_REGS(8),
                   .RO_MASK(8'h80), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REG_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
        .status_in(status0), .regs_out(regs0), .wr_pulse(pulse0));

    apb_reg_bank #(.AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .NUM_REGS(8),
                   .RO_MASK(8'h00), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_REG_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3),
        .status_in(status3), .regs_out(regs3), .wr_pulse(pulse3));

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends RESP.
    task automatic xfer(input int which, input logic wr, input logic [19:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err,
                        output logic [7:0] pls, output int lat);
        logic rdy;
        paddr = addr; pwdata = wd; pwrite = wr; pstrb = strb; penable = 1'b0;
        if (which == 0) psel0 = 1'b1; else psel3 = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 1;
        rdy = (which == 0) ? pready0 : pready3;
        while (!rdy && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            rdy = (which == 0) ? pready0 : pready3;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL pready_timeout actual=0 required=1");
        end
        rd  = (which == 0) ? prdata0 : prdata3;
        err = (which == 0) ? pslverr0 : pslverr3;
        @(posedge clk); #1;
        pls = (which == 0) ? pulse0 : pulse3;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [7:0]  pls;
        int          lat;
        logic        seen;

        rst = 1'b1; paddr = '0; pwdata = '0; pstrb = 4'hF;
        penable = 1'b0; pwrite = 1'b0; psel0 = 1'b0; psel3 = 1'b0;
        status0 = '0; status0[7*32 +: 32] = 32'h12345678;
        status3 = '0;

        for (int i = 0; i < 7; i++)
            vecs[i] = '{1'b0, 20'(i*4), 32'h0, 4'hF, 32'h0, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 20'h0001C, 32'h0,        4'hF, 32'h12345678, 1'b0, 8'h00};
        vecs[8]  = '{1'b1, 20'h00008, 32'hDEADBEEF, 4'hF, 32'h12345678, 1'b0, 8'h04};
        vecs[9]  = '{1'b0, 20'h00008, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 8'h00};
        vecs[10] = '{1'b1, 20'h0001C, 32'hAAAA5555, 4'hF, 32'hDEADBEEF, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 20'h0001C, 32'h0,        4'hF, 32'h12345678, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 20'h00020, 32'h0,        4'hF, 32'h00000000, 1'b1, 8'h00};
        vecs[13] = '{1'b1, 20'h00024, 32'h55555555, 4'hF, 32'h00000000, 1'b1, 8'h00};
        vecs[14] = '{1'b1, 20'h00000, 32'h00000001, 4'hF, 32'h00000000, 1'b0, 8'h01};
        vecs[15] = '{1'b1, 20'h00018, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0, 8'h40};
        vecs[16] = '{1'b0, 20'h00000, 32'h0,        4'hF, 32'h00000001, 1'b0, 8'h00};
        vecs[17] = '{1'b0, 20'h00018, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 20'hFFFFC, 32'h0,        4'hF, 32'h00000000, 1'b1, 8'h00};
        vecs[19] = '{1'b0, 20'h0000B, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 8'h00};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_prdata",  prdata0, 32'h0);
        check("reset_pready",  {31'b0, pready0}, 32'h0);
        check("reset_pslverr", {31'b0, pslverr0}, 32'h0);
        check("reset_regs",    regs0[31:0] | regs0[63:32] | regs0[223:192], 32'h0);
        check("reset_pulse",   {24'b0, pulse0}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, pls, lat);
            check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_pulse", i), {24'b0, pls}, {24'b0, vecs[i].exp_pulse});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end
        check("regs_out_slice2", regs0[2*32 +: 32], 32'hDEADBEEF);
        check("regs_out_slice0", regs0[0 +: 32],    32'h00000001);
        check("regs_out_slice6", regs0[6*32 +: 32], 32'hCAFEF00D);
        check("regs_out_ro_slice7", regs0[7*32 +: 32], 32'h0);

        // PSEL & PENABLE without a setup phase is ignored
        paddr = 20'h0; pwdata = 32'hFFFFFFFF; pwrite = 1'b1; psel0 = 1'b1; penable = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | pready0 | (|pulse0);
        end
        psel0 = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("proto_err_no_ready", {31'b0, seen}, 32'h0);
        check("proto_err_reg0", regs0[0 +: 32], 32'h00000001);

`ifdef APB_REG_PSTRB_EN
        xfer(0, 1'b1, 20'h00010, 32'hFFFFFFFF, 4'hF, rd, err, pls, lat);
        xfer(0, 1'b1, 20'h00010, 32'h00000000, 4'b0101, rd, err, pls, lat);
        check("strb_partial_value", regs0[4*32 +: 32], 32'hFF00FF00);
        check("strb_partial_pulse", {24'b0, pls}, 32'h10);
        xfer(0, 1'b1, 20'h00010, 32'h12345678, 4'b0000, rd, err, pls, lat);
        check("strb_zero_value", regs0[4*32 +: 32], 32'hFF00FF00);
        check("strb_zero_pulse", {24'b0, pls}, 32'h0);
        check("strb_zero_pslverr", {31'b0, err}, 32'h0);
        xfer(0, 1'b0, 20'h00010, 32'h0, 4'b0000, rd, err, pls, lat);
        check("strb_read_ignores", rd, 32'hFF00FF00);
`endif

        // three wait states: PREADY at T0+4
        xfer(1, 1'b1, 20'h00004, 32'h11112222, 4'hF, rd, err, pls, lat);
        check("w3_write_latency", 32'(lat), 32'd4);
        check("w3_write_pslverr", {31'b0, err}, 32'h0);
        check("w3_write_pulse", {24'b0, pls}, 32'h02);
        check("w3_write_value", regs3[1*32 +: 32], 32'h11112222);
        @(posedge clk); #1;
        check("w3_pulse_one_cycle", {24'b0, pulse3}, 32'h0);
        xfer(1, 1'b0, 20'h00004, 32'h0, 4'hF, rd, err, pls, lat);
        check("w3_read_latency", 32'(lat), 32'd4);
        check("w3_read_value", rd, 32'h11112222);

        // abort: PSEL dropped in T0+2
        paddr = 20'h00004; pwdata = 32'h33333333; pwrite = 1'b1; pstrb = 4'hF;
        psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        seen = pready3;
        @(posedge clk); #1 psel3 = 1'b0; penable = 1'b0;
        repeat (8) begin
            seen = seen | pready3 | (|pulse3);
            @(posedge clk); #1;
        end
        check("abort_no_ready_or_pulse", {31'b0, seen}, 32'h0);
        check("abort_reg_kept", regs3[1*32 +: 32], 32'h11112222);

        // reset while in WAIT
        paddr = 20'h0000C; pwdata = 32'h77777777; pwrite = 1'b1; psel3 = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; psel3 = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            seen = seen | pready3 | (|pulse3);
            @(posedge clk); #1;
        end
        check("rst_wait_no_ready", {31'b0, seen}, 32'h0);
        check("rst_wait_reg3", regs3[3*32 +: 32], 32'h0);
        xfer(1, 1'b1, 20'h0000C, 32'h5A5A5A5A, 4'hF, rd, err, pls, lat);
        check("post_rst_write_latency", 32'(lat), 32'd4);
        check("post_rst_write_pulse", {24'b0, pls}, 32'h08);
        xfer(1, 1'b0, 20'h0000C, 32'h0, 4'hF, rd, err, pls, lat);
        check("post_rst_read_value", rd, 32'h5A5A5A5A);
        check("post_rst_read_pslverr", {31'b0, err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
